// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl
// Program-load sequencer. While loading it owns the imem/dmem write ports and
// holds the core in reset. A UART byte stream is parsed as:
//   N_I (4 bytes LE), N_D (4 bytes LE), N_I instruction words, N_D data words
// where every word is little-endian. Instructions are packed four per 128-bit
// imem line, and data words are written one per dmem strobe.
//
// Ports:
//   clk           system clock
//   reset_x       asynchronous active-low reset
//   rx_valid      one-cycle strobe, rx_data holds a received byte
//   rx_data       received byte
//   prog_loading  loader owns memories (also core reset)
//   prog_loadaddr byte address of current write
//   prog_loaddata write data (imem: full line, dmem: [127:96])
//   prog_imem_we  one-cycle imem line write strobe
//   prog_dmem_we  one-cycle dmem word write strobe
//   done          load finished, sticky until reset
//   err           header count exceeds capacity, sticky until reset
module prog_load_ctrl #(
    parameter int ADDR_LEN   = 32,
    parameter int IMEM_LINES = 512,
    parameter int DMEM_WORDS = 2048,
    parameter int DMEM_BASE  = 0
) (
    input  logic                clk,
    input  logic                reset_x,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                prog_loading,
    output logic [ADDR_LEN-1:0] prog_loadaddr,
    output logic [127:0]        prog_loaddata,
    output logic                prog_imem_we,
    output logic                prog_dmem_we,
    output logic                done,
    output logic                err
);

    localparam int LINE_W = $clog2(IMEM_LINES);
    localparam int WORD_W = $clog2(DMEM_WORDS);
    localparam logic [31:0] IMEM_CAP = 32'(4 * IMEM_LINES);
    localparam logic [31:0] DMEM_CAP = 32'(DMEM_WORDS);

    typedef enum logic [2:0] {
        HDR_I, HDR_D, CHECK, INSN, FLUSH, DATA, FIN, ERR
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]          byte_cnt_reg;
    logic [23:0]         asm_word;
    logic [31:0]         n_i_reg;
    logic [31:0]         n_d_reg;
    logic [127:0]        line_buf_reg;
    logic [1:0]          slot_reg;
    logic [LINE_W-1:0]   line_index_reg;
    logic [WORD_W-1:0]   word_index_reg;
    logic [ADDR_LEN-1:0] addr_reg;
    logic [127:0]        data_reg;
    logic                imem_we_reg;
    logic                dmem_we_reg;
    logic                done_reg;

    logic        accepting;
    logic        byte_ok;
    logic        word_done;
    logic [31:0] word_val;
    logic        over_cap;
    logic        more_data;

    // Bytes are taken in every phase up to and including DATA; this lets a
    // byte arriving during CHECK or FLUSH count toward the following word.
    assign accepting = (state_reg != FIN) && (state_reg != ERR);
    assign byte_ok   = rx_valid && accepting;
    assign word_done = byte_ok && (byte_cnt_reg == 2'd3);
    // The fourth byte is used straight from the input, so only three lanes
    // need storage.
    assign word_val  = {rx_data, asm_word};
    assign over_cap  = (n_i_reg > IMEM_CAP) || (n_d_reg > DMEM_CAP);
    assign more_data = (n_d_reg != 32'd0);

    // Byte lanes of the word assembler: lane gi captures byte gi of a word.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge reset_x) begin
                if (!reset_x) begin
                    lane_reg <= 8'd0;
                end else if (byte_ok && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg <= rx_data;
                end
            end
            assign asm_word[8*gi +: 8] = lane_reg;
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_reg <= HDR_I;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HDR_I: if (word_done) state_next = HDR_D;
            HDR_D: if (word_done) state_next = CHECK;
            CHECK: begin
                if (over_cap)                state_next = ERR;
                else if (n_i_reg != 32'd0)   state_next = INSN;
                else if (more_data)          state_next = DATA;
                else                         state_next = FIN;
            end
            INSN: begin
                if (word_done && (n_i_reg == 32'd1)) begin
                    if (slot_reg != 2'd3)    state_next = FLUSH;
                    else if (more_data)      state_next = DATA;
                    else                     state_next = FIN;
                end
            end
            FLUSH: state_next = more_data ? DATA : FIN;
            DATA:  if (word_done && (n_d_reg == 32'd1)) state_next = FIN;
            FIN:   state_next = FIN;
            ERR:   state_next = ERR;
            default: state_next = HDR_I;
        endcase
    end

    // Datapath: counters, line buffer and registered write port
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            byte_cnt_reg   <= 2'd0;
            n_i_reg        <= 32'd0;
            n_d_reg        <= 32'd0;
            line_buf_reg   <= 128'd0;
            slot_reg       <= 2'd0;
            line_index_reg <= '0;
            word_index_reg <= '0;
            addr_reg       <= '0;
            data_reg       <= 128'd0;
            imem_we_reg    <= 1'b0;
            dmem_we_reg    <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            imem_we_reg <= 1'b0;
            dmem_we_reg <= 1'b0;

            if (byte_ok) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end

            case (state_reg)
                HDR_I: if (word_done) n_i_reg <= word_val;
                HDR_D: if (word_done) n_d_reg <= word_val;
                INSN: begin
                    if (word_done) begin
                        n_i_reg  <= n_i_reg - 32'd1;
                        slot_reg <= slot_reg + 2'd1;
                        if (slot_reg == 2'd3) begin
                            // Line complete: capture it together with the
                            // incoming word so the buffer can clear at once.
                            data_reg       <= {word_val, line_buf_reg[95:0]};
                            addr_reg       <= ADDR_LEN'({line_index_reg, 4'b0000});
                            imem_we_reg    <= 1'b1;
                            line_index_reg <= line_index_reg + LINE_W'(1);
                            line_buf_reg   <= 128'd0;
                        end else begin
                            line_buf_reg[{slot_reg, 5'b00000} +: 32] <= word_val;
                        end
                    end
                end
                FLUSH: begin
                    // Partial last line; unfilled slots are still zero.
                    data_reg       <= line_buf_reg;
                    addr_reg       <= ADDR_LEN'({line_index_reg, 4'b0000});
                    imem_we_reg    <= 1'b1;
                    line_index_reg <= line_index_reg + LINE_W'(1);
                    line_buf_reg   <= 128'd0;
                    slot_reg       <= 2'd0;
                end
                DATA: begin
                    if (word_done) begin
                        n_d_reg        <= n_d_reg - 32'd1;
                        data_reg       <= {word_val, 96'd0};
                        addr_reg       <= ADDR_LEN'(DMEM_BASE) +
                                          ADDR_LEN'({word_index_reg, 2'b00});
                        dmem_we_reg    <= 1'b1;
                        word_index_reg <= word_index_reg + WORD_W'(1);
                    end
                end
                default: ;
            endcase

            // FIN may be entered in the same cycle as the final strobe is
            // registered; done rises only once that strobe has been issued.
            // With nothing to load, done rises straight out of CHECK.
            if ((state_reg == FIN) ||
                ((state_reg == CHECK) && (state_next == FIN))) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign prog_loading  = ~done_reg;
    assign prog_loadaddr = addr_reg;
    assign prog_loaddata = data_reg;
    assign prog_imem_we  = imem_we_reg;
    assign prog_dmem_we  = dmem_we_reg;
    assign done          = done_reg;
    assign err           = (state_reg == ERR);

endmodule
